// File: rtl/uart_rx.sv
// 16550-style UART receiver: synchronized line, 16x oversampled framing FSM,
// RX FIFO carrying per-character PE/FE/BI, line-status and interrupt conditions.
module uart_rx #(
    parameter int FIFO_DEPTH  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          tick16_i,
    input  logic                          rx_i,
    input  logic [1:0]                    wls_i,
    input  logic                          pen_i,
    input  logic                          eps_i,
    input  logic                          fifo_en_i,
    input  logic                          fifo_clr_i,
    input  logic [1:0]                    trig_i,
    input  logic                          rd_en_i,
    input  logic                          lsr_rd_i,
    output logic [7:0]                    rd_data_o,
    output logic                          rd_pe_o,
    output logic                          rd_fe_o,
    output logic                          rd_bi_o,
    output logic [$clog2(FIFO_DEPTH):0]   count_o,
    output logic                          dr_o,
    output logic                          oe_o,
    output logic                          rxfe_o,
    output logic                          trig_o,
    output logic                          timeout_o
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BRK_WAIT} state_t;

    // ---------------- line synchronizer ----------------
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rxs;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) sync_q <= '1;
        else      sync_q <= {sync_q[SYNC_STAGES-2:0], rx_i};
    end
    assign rxs = sync_q[SYNC_STAGES-1];

    // ---------------- framing FSM ----------------
    state_t      state, state_nx;
    logic [3:0]  sc, sc_nx;
    logic [2:0]  bit_cnt, bit_cnt_nx;
    logic [7:0]  shreg, shreg_nx;
    logic        par_bit, par_bit_nx;
    logic [2:0]  last_bit;
    logic        push, pe, fe, bi;
    logic [10:0] push_ent;

    assign last_bit = 3'd4 + {1'b0, wls_i};
    // Shift register is cleared per frame, so short words are already zero-extended.
    assign pe = pen_i & ((^shreg ^ par_bit) == eps_i);
    assign fe = ~rxs;
    assign bi = (shreg == 8'h00) & ~par_bit & ~rxs;
    assign push_ent = {bi, fe, pe, shreg};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            sc      <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
            par_bit <= 1'b0;
        end else begin
            state   <= state_nx;
            sc      <= sc_nx;
            bit_cnt <= bit_cnt_nx;
            shreg   <= shreg_nx;
            par_bit <= par_bit_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        sc_nx      = sc;
        bit_cnt_nx = bit_cnt;
        shreg_nx   = shreg;
        par_bit_nx = par_bit;
        push       = 1'b0;
        if (tick16_i) begin
            sc_nx = sc + 4'd1;
            case (state)
                IDLE: begin
                    sc_nx = '0;
                    if (!rxs) begin
                        state_nx   = START;
                        bit_cnt_nx = '0;
                        shreg_nx   = '0;
                        par_bit_nx = 1'b0;
                    end
                end
                START: if (sc == 4'd7) begin
                    sc_nx    = '0;
                    state_nx = rxs ? IDLE : DATA;
                end
                DATA: if (sc == 4'd15) begin
                    shreg_nx[bit_cnt] = rxs;
                    bit_cnt_nx        = bit_cnt + 3'd1;
                    if (bit_cnt == last_bit) state_nx = pen_i ? PARITY : STOP;
                end
                PARITY: if (sc == 4'd15) begin
                    par_bit_nx = rxs;
                    state_nx   = STOP;
                end
                STOP: if (sc == 4'd15) begin
                    push     = 1'b1;
                    state_nx = bi ? BRK_WAIT : IDLE;
                end
                BRK_WAIT: if (rxs) state_nx = IDLE;
                default: state_nx = IDLE;
            endcase
        end
    end

    // ---------------- RX FIFO ----------------
    logic [10:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count, err_cnt, cap;
    logic [10:0]   head;
    logic          full, do_pop, do_push, ovr, head_err, push_err;

    assign cap      = fifo_en_i ? CW'(FIFO_DEPTH) : CW'(1);
    assign full     = count >= cap;
    assign do_pop   = rd_en_i && (count != '0);
    // A same-cycle pop frees the slot, so a full FIFO still accepts the push.
    assign do_push  = push && (!full || do_pop);
    assign ovr      = push && full && !do_pop && !fifo_clr_i;
    assign head     = mem[rd_ptr];
    assign head_err = |head[10:8];
    assign push_err = |push_ent[10:8];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            err_cnt <= '0;
        end else if (fifo_clr_i) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            err_cnt <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count   <= count + CW'(do_push) - CW'(do_pop);
            err_cnt <= err_cnt + CW'(do_push && push_err) - CW'(do_pop && head_err);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !fifo_clr_i) mem[wr_ptr] <= push_ent;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)          oe_o <= 1'b0;
        else if (ovr)      oe_o <= 1'b1;
        else if (lsr_rd_i) oe_o <= 1'b0;
    end

    // ---------------- character timeout ----------------
    logic [3:0] frame_bits;
    logic [9:0] to_limit, to_cnt;
    logic       to_rst;

    assign frame_bits = 4'd7 + {2'b00, wls_i} + {3'b000, pen_i};
    assign to_limit   = {frame_bits, 6'b000000};
    assign to_rst     = push || do_pop || fifo_clr_i || (state == IDLE && state_nx != IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)        to_cnt <= '0;
        else if (to_rst) to_cnt <= '0;
        else if (tick16_i && state == IDLE && count != '0 && to_cnt < to_limit)
            to_cnt <= to_cnt + 10'd1;
    end

    // ---------------- status outputs ----------------
    logic [31:0] trig_lvl;

    always_comb begin
        case (trig_i)
            2'b00:   trig_lvl = 32'd1;
            2'b01:   trig_lvl = 32'd4;
            2'b10:   trig_lvl = 32'd8;
            default: trig_lvl = 32'd14;
        endcase
    end

    assign dr_o      = count != '0;
    assign count_o   = count;
    assign rd_data_o = dr_o ? head[7:0] : 8'h00;
    assign rd_pe_o   = dr_o & head[8];
    assign rd_fe_o   = dr_o & head[9];
    assign rd_bi_o   = dr_o & head[10];
    assign rxfe_o    = err_cnt != '0;
    assign trig_o    = fifo_en_i ? (32'(count) >= trig_lvl) : dr_o;
    assign timeout_o = to_cnt >= to_limit;
endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: framing, parity/framing/break flags, FIFO overrun,
// triggers, character timeout and asynchronous reset.
`timescale 1ns/1ps
module tb_uart_rx;
    logic       clk = 1'b0, rst = 1'b0, tick16 = 1'b0, rx = 1'b1;
    logic [1:0] wls = 2'b11, trig = 2'b00;
    logic       pen = 1'b0, eps = 1'b0, fifo_en = 1'b1, fifo_clr = 1'b0;
    logic       rd_en = 1'b0, lsr_rd = 1'b0;
    logic [7:0] rd_data;
    logic       rd_pe, rd_fe, rd_bi, dr, oe, rxfe, trig_hit, timeout;
    logic [4:0] count;
    int         n_run = 0, n_fail = 0, k_push = 0, div = 0;

    uart_rx #(.FIFO_DEPTH(16), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .tick16_i(tick16), .rx_i(rx), .wls_i(wls),
        .pen_i(pen), .eps_i(eps), .fifo_en_i(fifo_en), .fifo_clr_i(fifo_clr),
        .trig_i(trig), .rd_en_i(rd_en), .lsr_rd_i(lsr_rd), .rd_data_o(rd_data),
        .rd_pe_o(rd_pe), .rd_fe_o(rd_fe), .rd_bi_o(rd_bi), .count_o(count),
        .dr_o(dr), .oe_o(oe), .rxfe_o(rxfe), .trig_o(trig_hit), .timeout_o(timeout)
    );

    always #5 clk = ~clk;

    // 16x enable: one cycle in four, changed on the falling edge
    initial forever begin
        @(negedge clk);
        div    = (div + 1) % 4;
        tick16 = (div == 0);
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_run++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            do @(posedge clk); while (!tick16);
        end
        #1;
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        wait_ticks(16);
    endtask

    task automatic send_head(input logic [7:0] d, input int nb, input logic p_en, input logic pb);
        send_bit(1'b0);
        for (int i = 0; i < nb; i++) send_bit(d[i]);
        if (p_en) send_bit(pb);
    endtask

    task automatic send_frame(input logic [7:0] d, input int nb, input logic p_en,
                              input logic pb, input logic stop);
        send_head(d, nb, p_en, pb);
        send_bit(stop);
        rx = 1'b1;
    endtask

    task automatic pop();
        rd_en = 1'b1;
        @(posedge clk); #1;
        rd_en = 1'b0;
    endtask

    // holds rd_en across exactly the next tick edge
    task automatic pop_at_tick();
        do begin @(negedge clk); #1; end while (!tick16);
        rd_en = 1'b1;
        @(posedge clk); #1;
        rd_en = 1'b0;
    endtask

    initial begin
        logic [7:0] exp_d;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_count", 32'(count), 0);
        chk("rst_dr", 32'(dr), 0);
        chk("rst_oe", 32'(oe), 0);
        chk("rst_data", 32'(rd_data), 0);
        chk("rst_misc", 32'({rxfe, trig_hit, timeout}), 0);
        rst = 1'b1;
        wait_ticks(4);

        // 8N1 0x55; measure push latency from stop-bit start
        send_head(8'h55, 8, 1'b0, 1'b0);
        rx = 1'b1;
        while (!dr && k_push < 24) begin
            wait_ticks(1);
            k_push++;
        end
        chk("t1_dr", 32'(dr), 1);
        chk("t1_data", 32'(rd_data), 32'h55);
        chk("t1_flags", 32'({rd_pe, rd_fe, rd_bi}), 0);
        chk("t1_count", 32'(count), 1);
        pop();
        chk("t1_pop_count", 32'(count), 0);
        chk("t1_pop_dr", 32'(dr), 0);

        // 7E1 0x41 with wrong parity bit
        wls = 2'b10; pen = 1'b1; eps = 1'b1;
        send_frame(8'h41, 7, 1'b1, 1'b1, 1'b1);
        chk("t2_data", 32'(rd_data), 32'h41);
        chk("t2_pe", 32'(rd_pe), 1);
        chk("t2_fe_bi", 32'({rd_fe, rd_bi}), 0);
        chk("t2_rxfe", 32'(rxfe), 1);
        pop();
        chk("t2_pop_rxfe", 32'(rxfe), 0);

        // framing error then line held low: one break entry only
        wls = 2'b11; pen = 1'b0; eps = 1'b0;
        send_head(8'hA3, 8, 1'b0, 1'b0);
        rx = 1'b0;
        wait_ticks(16 + 480);
        chk("t3_count", 32'(count), 2);
        chk("t3_fe_data", 32'(rd_data), 32'hA3);
        chk("t3_fe_flags", 32'({rd_bi, rd_fe, rd_pe}), 32'b010);
        pop();
        chk("t3_bi_data", 32'(rd_data), 0);
        chk("t3_bi_flags", 32'({rd_bi, rd_fe, rd_pe}), 32'b110);
        chk("t3_rxfe", 32'(rxfe), 1);
        wait_ticks(200);
        chk("t3_no_extra", 32'(count), 1);
        fifo_clr = 1'b1;
        @(posedge clk); #1;
        fifo_clr = 1'b0;
        chk("t3_clr_count", 32'(count), 0);
        chk("t3_clr_rxfe", 32'(rxfe), 0);
        rx = 1'b1;
        wait_ticks(20);
        send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b1);
        chk("t3_after_brk", 32'(rd_data), 32'h5A);
        pop();

        // overrun with 17 bytes into 16 entries
        for (int i = 0; i < 17; i++) send_frame(8'(i), 8, 1'b0, 1'b0, 1'b1);
        chk("t4_count", 32'(count), 16);
        chk("t4_oe", 32'(oe), 1);
        chk("t4_head", 32'(rd_data), 0);
        lsr_rd = 1'b1;
        @(posedge clk); #1;
        lsr_rd = 1'b0;
        chk("t4_oe_clr", 32'(oe), 0);
        send_head(8'h11, 8, 1'b0, 1'b0);
        rx = 1'b1;
        wait_ticks(k_push - 1);
        pop_at_tick();
        wait_ticks(4);
        chk("t4_pp_count", 32'(count), 16);
        chk("t4_pp_oe", 32'(oe), 0);
        for (int i = 0; i < 16; i++) begin
            exp_d = (i < 15) ? 8'(i + 1) : 8'h11;
            chk($sformatf("t4_drain%0d", i), 32'(rd_data), 32'(exp_d));
            pop();
        end
        chk("t4_empty", 32'(count), 0);

        // short low glitch, then trigger level 4
        rx = 1'b0;
        wait_ticks(5);
        rx = 1'b1;
        wait_ticks(24);
        chk("t5_glitch", 32'(count), 0);
        trig = 2'b01;
        for (int i = 0; i < 3; i++) send_frame(8'hC0 + 8'(i), 8, 1'b0, 1'b0, 1'b1);
        chk("t5_trig3", 32'(trig_hit), 0);
        send_frame(8'hC3, 8, 1'b0, 1'b0, 1'b1);
        chk("t5_trig4", 32'(trig_hit), 1);
        chk("t5_head", 32'(rd_data), 32'hC0);
        fifo_clr = 1'b1;
        @(posedge clk); #1;
        fifo_clr = 1'b0;
        chk("t5_clr", 32'(count), 0);
        trig = 2'b00;

        // timeout: 8N1 -> 640 ticks after the push
        send_head(8'h77, 8, 1'b0, 1'b0);
        rx = 1'b1;
        wait_ticks(k_push);
        chk("t6_dr", 32'(dr), 1);
        wait_ticks(639);
        chk("t6_to_639", 32'(timeout), 0);
        wait_ticks(1);
        chk("t6_to_640", 32'(timeout), 1);
        pop();
        chk("t6_to_pop", 32'(timeout), 0);

        // capacity 1 overrun, then async reset mid-DATA
        fifo_en = 1'b0;
        send_frame(8'h12, 8, 1'b0, 1'b0, 1'b1);
        send_frame(8'h34, 8, 1'b0, 1'b0, 1'b1);
        chk("t7_cap1_oe", 32'(oe), 1);
        chk("t7_cap1_data", 32'(rd_data), 32'h12);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        rst = 1'b0;
        #1;
        chk("t7_rst_count", 32'(count), 0);
        chk("t7_rst_oe", 32'(oe), 0);
        chk("t7_rst_data", 32'(rd_data), 0);
        chk("t7_rst_misc", 32'({dr, rxfe, timeout, trig_hit}), 0);
        rx = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        fifo_en = 1'b1;
        wait_ticks(24);
        send_frame(8'h3C, 8, 1'b0, 1'b0, 1'b1);
        chk("t7_after_data", 32'(rd_data), 32'h3C);
        chk("t7_after_count", 32'(count), 1);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Receive path of the 16550-style UART: serial rx_i → start-bit qualify → mid-bit sampling → shift register → 16-entry RX FIFO with per-entry error flags.
- Sits beside the transmitter and shares its 16x oversample enable from the baud generator.
- Supplies the data port behind RHR and the line-status bits DR/OE/PE/FE/BI/RXFE to the bus/register front end.
- Produces the RX-data-available and character-timeout interrupt conditions.

Parameters:
- FIFO_DEPTH, 16, RX FIFO entries; power of two, at least 2.
- SYNC_STAGES, 2, synchronizer flops on rx_i; at least 2.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- tick16_i  in  1  one-cycle enable at 16x baud.
- rx_i  in  1  serial input, idle high.
- wls_i  in  2  word length (LCR[1:0]): 00=5, 01=6, 10=7, 11=8 bits.
- pen_i  in  1  parity enable (LCR[3]).
- eps_i  in  1  even parity select (LCR[4]).
- fifo_en_i  in  1  FCR[0]; when 0, capacity is 1.
- fifo_clr_i  in  1  one-cycle RX FIFO flush.
- trig_i  in  2  trigger level: 00=1, 01=4, 10=8, 11=14.
- rd_en_i  in  1  pop head entry (RHR read).
- lsr_rd_i  in  1  LSR read strobe; clears OE.
- rd_data_o  out  8  head data (show-ahead), zero-extended above the word length.
- rd_pe_o / rd_fe_o / rd_bi_o  out  1 each  head entry flags.
- count_o  out  $clog2(FIFO_DEPTH)+1  entries held.
- dr_o  out  1  count_o != 0.
- oe_o  out  1  sticky overrun.
- rxfe_o  out  1  at least one held entry has PE, FE or BI.
- trig_o  out  1  count_o >= trigger level.
- timeout_o  out  1  character timeout.

Behaviour:
- Reset values:
  - Outputs: all 0, except rd_data_o = 0.
  - Internal state: sync chain = 1, state IDLE, pointers/counters 0.
- rx_i passes through SYNC_STAGES flops before any use (rxs).
- The FSM advances only on tick16_i, with a 4-bit sample counter sc.
  - IDLE: rxs == 0 on a tick → START, sc = 0.
  - START: at sc == 7, if rxs == 1 it is a glitch → IDLE, no push; else sc = 0 → DATA.
  - DATA: sample rxs at sc == 15 (mid-bit) into the shift register, LSB first. After wls+5 bits → PARITY if pen_i, else STOP.
  - PARITY: sample at sc == 15. PE = (XOR of data bits ^ sampled bit) != eps_i? 0 : 1 — i.e. even: total ones incl. parity must be even; odd: must be odd.
  - STOP: sample at sc == 15, only the first stop bit is checked.
    - FE = sampled bit is 0.
    - BI = data, parity and stop all 0.
    - Push {BI, FE, PE, data} in the same cycle. On BI → BRK_WAIT, else → IDLE.
  - BRK_WAIT: stay until rxs == 1 on a tick, then → IDLE. Only one entry is pushed per break.
- Capacity: FIFO_DEPTH when fifo_en_i = 1, else 1.
  - Push when full: entry discarded, oe_o = 1, FIFO contents unchanged.
- Pop:
  - rd_en_i with count 0 is ignored.
  - Pop and push in the same cycle: count unchanged and no overrun, even when full.
  - Pointers wrap modulo FIFO_DEPTH.
- oe_o clears on lsr_rd_i, unless a new overrun occurs in the same cycle (set wins).
- rxfe_o: tracks a count of error-flagged entries, incremented on push and decremented on pop of a flagged entry; cleared by flush.
- fifo_clr_i:
  - Next cycle: count 0, pointers 0, rxfe_o 0.
  - A frame in progress is not aborted. oe_o is not affected.
- timeout_o:
  - Counter counts ticks while count_o != 0 and the FSM is in IDLE.
  - Counter resets on push, pop, flush, or leaving IDLE.
  - Asserts when the counter reaches 64 × frame_bits, where frame_bits = 1 + (wls+5) + pen + 1.
  - Deasserts on the same events that reset the counter.
- trig_o is compared against the trigger level only when fifo_en_i = 1; otherwise trig_o = dr_o.
- Changing wls_i/pen_i mid-frame is undefined; the block must not hang, and IDLE is always reached within 2 frame times of line idle.

Test Plan:
- 8N1, tick16 every 4 clks, send 0x55 → one entry 0x55, flags 000, dr_o = 1 after the stop-bit sample; rd_en_i → count 0, dr_o = 0.
- 7E1, send 0x41 with parity bit 1 (wrong) → rd_data_o = 0x41, rd_pe_o = 1, rxfe_o = 1; pop → rxfe_o = 0.
- 8N1, 0xA3 with stop bit 0 → FE = 1, BI = 0; then hold line low 3 frames → exactly one entry 0x00 with BI = FE = 1, then FSM returns to IDLE only after the line goes high.
- fifo_en_i = 1, send 17 bytes 0x00..0x10 with no pops → count 16, oe_o = 1, head 0x00, tail 0x0F; lsr_rd_i → oe_o = 0; pop on the same cycle as the 17th stop sample → no overrun.
- Low pulse of 5 ticks on rx_i in IDLE → no push, back to IDLE; trig_i = 01 with 4 bytes → trig_o = 1 on the 4th push.
- 8N1, one byte held and idle → timeout_o = 1 after exactly 640 ticks; rd_en_i → timeout_o = 0; async rst mid-DATA → all outputs 0, next frame received correctly.
